// File: rtl/bank_pkg.sv
// Shared grant encoding and default geometry for the register-bank arbiter.
package bank_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 3;
  localparam int DEF_STARVE_MAX = 15;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_DSP  = 2'd3
  } grant_e;

endpackage

// File: rtl/bank_wbuf.sv
// One-entry keypad write buffer with the starvation counter that lets a
// long-denied write preempt the VGA reader.
module bank_wbuf
  import bank_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kb_req,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_data,
  input  logic              wr_gnt,
  output logic              wb_full,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              kb_ack,
  output logic              starve_hit
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic              wb_full_q, wb_full_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              kb_ack_q, kb_ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wb_full_d = wb_full_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    kb_ack_d  = 1'b0;
    cnt_d     = cnt_q;

    // Capture only into an empty buffer; a grant always finds it full, so
    // a request alongside a grant waits for the next cycle.
    if (kb_req && !wb_full_q) begin
      wb_full_d = 1'b1;
      wb_addr_d = kb_addr;
      wb_data_d = kb_data;
      kb_ack_d  = 1'b1;
    end else if (wr_gnt) begin
      wb_full_d = 1'b0;
    end

    if (!wb_full_q || wr_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_full_q <= 1'b0;
      kb_ack_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wb_full_q <= wb_full_d;
      kb_ack_q  <= kb_ack_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload is qualified by wb_full, so it carries no reset.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  assign wb_full    = wb_full_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign kb_ack     = kb_ack_q;
  assign starve_hit = wb_full_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/bank_arbiter.sv
// Single-port register-bank arbiter: VGA read first, keypad write and
// 7-segment read round-robin, with write starvation preemption and forwarding.
module bank_arbiter
  import bank_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              kb_req,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_data,
  output logic              kb_ack,
  output logic              kb_busy,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic [DATA_W-1:0] dsp_data,
  output logic              dsp_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_e            gnt;
  logic              wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              starve_hit;
  logic [DATA_W-1:0] rd_val;

  logic              rr_ptr_q, rr_ptr_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              dsp_valid_q, dsp_valid_d;
  logic [DATA_W-1:0] dsp_data_q, dsp_data_d;

  bank_wbuf #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .kb_req    (kb_req),
    .kb_addr   (kb_addr),
    .kb_data   (kb_data),
    .wr_gnt    (gnt == GNT_WR),
    .wb_full   (wb_full),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .kb_ack    (kb_ack),
    .starve_hit(starve_hit)
  );

  // rr_ptr_q = 0 favours the write, 1 favours the display.
  always_comb begin
    gnt = GNT_NONE;
    if (starve_hit) begin
      gnt = GNT_WR;
    end else if (vga_req) begin
      gnt = GNT_VGA;
    end else if (wb_full && dsp_req) begin
      gnt = rr_ptr_q ? GNT_DSP : GNT_WR;
    end else if (wb_full) begin
      gnt = GNT_WR;
    end else if (dsp_req) begin
      gnt = GNT_DSP;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (gnt)
      GNT_VGA: mem_addr = vga_addr;
      GNT_DSP: mem_addr = dsp_addr;
      GNT_WR: begin
        mem_addr  = wb_addr;
        mem_we    = 1'b1;
        mem_wdata = wb_data;
      end
      default: ;
    endcase
  end

  // A read of the address still sitting in the buffer must see the new value.
  assign rd_val = (wb_full && (mem_addr == wb_addr)) ? wb_data : mem_rdata;

  always_comb begin
    rr_ptr_d    = rr_ptr_q ^ ((gnt == GNT_WR) || (gnt == GNT_DSP));
    vga_valid_d = (gnt == GNT_VGA);
    vga_data_d  = (gnt == GNT_VGA) ? rd_val : vga_data_q;
    dsp_valid_d = (gnt == GNT_DSP);
    dsp_data_d  = (gnt == GNT_DSP) ? rd_val : dsp_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
    end
  end

  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_data_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;
  assign kb_busy   = wb_full;

endmodule
